// File: rtl/alu_arbiter_if.sv
// Bundle of request, response and shared-ALU signals for alu_arbiter.
// slave is the arbiter side, master is the requester/ALU side.
interface alu_arbiter_if;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_ctrl, req1_ctrl;
    logic [4:0]  req0_shamt, req1_shamt;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp_data;
    logic        rsp_zero;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_ctrl;
    logic [4:0]  alu_shamt;
    logic        alu_zero;
    logic        busy;
    logic [15:0] ops_done;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_ctrl, req0_shamt,
        input  req1_valid, req1_a, req1_b, req1_ctrl, req1_shamt,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_data, rsp_zero,
        input  rsp0_ready, rsp1_ready,
        output alu_a, alu_b, alu_ctrl, alu_shamt,
        input  alu_out, alu_zero,
        output busy, ops_done
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_ctrl, req0_shamt,
        output req1_valid, req1_a, req1_b, req1_ctrl, req1_shamt,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_data, rsp_zero,
        output rsp0_ready, rsp1_ready,
        input  alu_a, alu_b, alu_ctrl, alu_shamt,
        output alu_out, alu_zero,
        input  busy, ops_done
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared combinational ALU.
// One operation in flight at a time: IDLE -> EXEC -> RESP -> IDLE.
module alu_arbiter (
    input  logic         clk,
    input  logic         reset,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state;
    logic        prio;
    logic        idx;
    logic [31:0] op_a, op_b;
    logic [3:0]  op_ctrl;
    logic [4:0]  op_shamt;
    logic [31:0] rsp_data_q;
    logic        rsp_zero_q;
    logic [15:0] ops_cnt;

    logic sel1, acc0, acc1, rsp_done;

    // Port 1 wins when it is the only requester or when both ask and prio points at it.
    assign sel1     = bus.req1_valid & (~bus.req0_valid | prio);
    assign acc0     = (state == IDLE) & ~reset & bus.req0_valid & ~sel1;
    assign acc1     = (state == IDLE) & ~reset & sel1;
    assign rsp_done = (state == RESP) & (idx ? bus.rsp1_ready : bus.rsp0_ready);

    assign bus.req0_ready = acc0;
    assign bus.req1_ready = acc1;
    assign bus.rsp0_valid = (state == RESP) & ~idx;
    assign bus.rsp1_valid = (state == RESP) & idx;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.alu_a      = op_a;
    assign bus.alu_b      = op_b;
    assign bus.alu_ctrl   = op_ctrl;
    assign bus.alu_shamt  = op_shamt;
    assign bus.busy       = (state != IDLE);
    assign bus.ops_done   = ops_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            prio       <= 1'b0;
            idx        <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            op_ctrl    <= '0;
            op_shamt   <= '0;
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
            ops_cnt    <= '0;
        end else begin
            case (state)
                IDLE: if (acc0 | acc1) begin
                    op_a     <= acc1 ? bus.req1_a     : bus.req0_a;
                    op_b     <= acc1 ? bus.req1_b     : bus.req0_b;
                    op_ctrl  <= acc1 ? bus.req1_ctrl  : bus.req0_ctrl;
                    op_shamt <= acc1 ? bus.req1_shamt : bus.req0_shamt;
                    idx      <= acc1;
                    state    <= EXEC;
                end
                EXEC: begin
                    rsp_data_q <= bus.alu_out;
                    rsp_zero_q <= bus.alu_zero;
                    state      <= RESP;
                end
                RESP: if (rsp_done) begin
                    ops_cnt <= ops_cnt + 16'd1;
                    prio    <= ~idx;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameters: none; datapath fixed at 32 bits, ALU control 4 bits, shift amount 5 bits.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 reqN_valid  input  1  (N=0,1) requester N presents an operation.
REQ-005 reqN_ready  output  1  operation from requester N accepted this cycle.
REQ-006 reqN_a, reqN_b  input  32 each  operands.
REQ-007 reqN_ctrl  input  4  ALU control code, passed through unmodified.
REQ-008 reqN_shamt  input  5  shift amount.
REQ-009 rspN_valid  output  1  result for requester N available.
REQ-010 rspN_ready  input  1  requester N consumes result.
REQ-011 rsp_data  output  32  result shared by both response ports.
REQ-012 rsp_zero  output  1  zero flag of result.
REQ-013 alu_a, alu_b  output  32 each  operands to the shared ALU.
REQ-014 alu_ctrl  output  4; alu_shamt  output  5  ALU control and shift amount.
REQ-015 alu_out  input  32; alu_zero  input  1  combinational ALU result and zero flag.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 ops_done  output  16  count of completed responses.

Function
REQ-018 FSM states SHALL be IDLE, EXEC, RESP.
REQ-019 IDLE: grant = valid requester if exactly one valid; if both valid, requester named by priority pointer (prio).
REQ-020 reqN_ready SHALL be high only in IDLE, only for granted N, combinational from reqN_valid; at most one ready per cycle.
REQ-021 On accept (valid & ready): latch a, b, ctrl, shamt and grant index into operand registers; next state EXEC.
REQ-022 alu_a/alu_b/alu_ctrl/alu_shamt SHALL always be driven from operand registers, never directly from request inputs.
REQ-023 EXEC lasts exactly one cycle; at its end alu_out/alu_zero are captured into rsp_data/rsp_zero; next state RESP.
REQ-024 RESP: rspN_valid high for latched index only; rsp_data/rsp_zero stable while rspN_valid high.
REQ-025 RESP exits to IDLE on the cycle rspN_ready is high; ops_done increments by 1 on that cycle, wrapping 0xFFFF -> 0x0000.
REQ-026 prio SHALL flip to the requester not served on each response completion (round-robin).
REQ-027 Latency: accept in cycle T -> rspN_valid first high in cycle T+2; minimum 3 cycles per operation.
REQ-028 No request is accepted in EXEC or RESP; request inputs there are ignored and reqN_ready stays low.
REQ-029 Unlisted ctrl codes pass through unmodified; the result is whatever the ALU returns.
REQ-030 rspN_ready while rspN_valid low SHALL have no effect.

Reset
REQ-031 reset SHALL force state IDLE, prio=0, operand registers 0, rsp_data=0, rsp_zero=0, ops_done=0.
REQ-032 All outputs 0 during and after reset until next accept: reqN_ready=0, rspN_valid=0, busy=0.
REQ-033 reset in EXEC or RESP SHALL abandon the operation: no response issued, ops_done unchanged at 0.
REQ-034 reset has priority over every other event in the same cycle.

Verification
REQ-035 Port 0 ADD (ctrl 0010) a=5, b=7 accepted cycle T -> rsp0_valid at T+2, rsp_data=12, rsp_zero=0, ops_done=1.
REQ-036 After reset both valid with SUB 9-9 (0110) on port 0 and OR 0xF0|0x0F (0001) on port 1 -> port 0 served first (data 0, zero=1), then port 1 (data 0xFF); rsp1_valid never overlaps rsp0_valid.
REQ-037 Port 1 SLL b=1, shamt=4 (0011), rsp1_ready held low 3 cycles -> rsp1_valid and rsp_data=16 stable throughout; reqN_ready stays 0 until the cycle after the rsp1_ready handshake.
REQ-038 Reset asserted during EXEC -> rsp0_valid and rsp1_valid stay 0, busy=0 next cycle, ops_done=0.
REQ-039 Force ops_done to 0xFFFF via 65535 ops, complete one more -> ops_done=0x0000.
REQ-040 Both ports continuously valid for 6 ops -> grants alternate 0,1,0,1,0,1.
